// File: rtl/datapath_bus.sv
// datapath_bus -- 16-bit single-bus datapath: register file, ALU and bus mux.
//
// A 4-bit source select places one register (or a memory read port) on the
// shared bus; per-register load, increment and clear strobes then update the
// registers on the next rising edge of clk. AC can also load the ALU result.
//
// Optional feature: define DATAPATH_R5_EN to add register R5 (load strobe
// bit 6, bus source 11). Without it, bit 6 of every strobe is ignored and
// source 11 drives zero.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   read_en[3:0]         bus source select
//   write_en[15:0]       per-destination load strobes (bit 11 = DM write,
//                        bit 12 = ALU result into AC)
//   inc_en[15:0]         per-register increment strobes
//   clr_en[15:0]         per-register clear strobes
//   alu_op[2:0]          ALU operation code
//   halt                 freezes all register updates and DM writes
//   im_addr, im_rdata    instruction memory (address = PC)
//   dm_addr, dm_wdata,
//   dm_we, dm_rdata      data memory (address = AR, write data = bus)
//   z                    {15'b0, AC == 0}
//   instruction          IR[5:0]
//   bus                  current bus value
module datapath_bus (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  read_en,
  input  logic [15:0] write_en,
  input  logic [15:0] inc_en,
  input  logic [15:0] clr_en,
  input  logic [2:0]  alu_op,
  input  logic        halt,
  output logic [15:0] im_addr,
  input  logic [15:0] im_rdata,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  output logic        dm_we,
  input  logic [15:0] dm_rdata,
  output logic [15:0] z,
  output logic [5:0]  instruction,
  output logic [15:0] bus
);

  typedef enum logic [3:0] {
    SRC_PC  = 4'd1,
    SRC_AR  = 4'd2,
    SRC_DR  = 4'd3,
    SRC_IR  = 4'd4,
    SRC_AC  = 4'd5,
    SRC_R   = 4'd6,
    SRC_R1  = 4'd7,
    SRC_R2  = 4'd8,
    SRC_R3  = 4'd9,
    SRC_R4  = 4'd10,
    SRC_R5  = 4'd11,
    SRC_DM  = 4'd12,
    SRC_IM  = 4'd13,
    SRC_AC2 = 4'd14
  } src_e;

  // Strobe bit positions shared by write_en, inc_en and clr_en.
  localparam int B_PC  = 1;
  localparam int B_AR  = 2;
  localparam int B_IR  = 3;
  localparam int B_AC  = 4;
  localparam int B_R   = 5;
  localparam int B_R5  = 6;
  localparam int B_R4  = 7;
  localparam int B_R3  = 8;
  localparam int B_R2  = 9;
  localparam int B_R1  = 10;
  localparam int B_DMW = 11;
  localparam int B_ALU = 12;

  logic [15:0] pc, ar, dr, ir, ac, r, r1, r2, r3, r4;
  logic [15:0] r5_val;
  logic [15:0] alu_y;

  // Clear beats load beats increment; increment wraps naturally at 16 bits.
  function automatic logic [15:0] next_val(input logic [15:0] cur,
                                           input logic [15:0] din,
                                           input logic clr,
                                           input logic wr,
                                           input logic inc);
    if (clr)      return 16'h0000;
    else if (wr)  return din;
    else if (inc) return cur + 16'h0001;
    else          return cur;
  endfunction

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, otherwise synthesis infers a latch.
  always_comb begin
    bus = 16'h0000;
    case (read_en)
      SRC_PC:  bus = pc;
      SRC_AR:  bus = ar;
      SRC_DR:  bus = dr;
      SRC_IR:  bus = ir;
      SRC_AC:  bus = ac;
      SRC_R:   bus = r;
      SRC_R1:  bus = r1;
      SRC_R2:  bus = r2;
      SRC_R3:  bus = r3;
      SRC_R4:  bus = r4;
      SRC_R5:  bus = r5_val;
      SRC_DM:  bus = dm_rdata;
      SRC_IM:  bus = im_rdata;
      SRC_AC2: bus = ac;
      default: bus = 16'h0000;
    endcase
  end

  always_comb begin
    alu_y = ac;
    case (alu_op)
      3'd1:    alu_y = ac + r;
      3'd2:    alu_y = ac - r;
      3'd3:    alu_y = ac * r;
      3'd4:    alu_y = {ac[14:0], 1'b0};
      default: alu_y = ac;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, letting simultaneous strobes all land together.
  // NOTE: the asynchronous reset clears every register immediately, without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      ar <= '0;
      dr <= '0;
      ir <= '0;
      ac <= '0;
      r  <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      r4 <= '0;
    end else if (!halt) begin
      pc <= next_val(pc, bus, clr_en[B_PC], write_en[B_PC], inc_en[B_PC]);
      ar <= next_val(ar, bus, clr_en[B_AR], write_en[B_AR], inc_en[B_AR]);
      ir <= next_val(ir, bus, clr_en[B_IR], write_en[B_IR], inc_en[B_IR]);
      r  <= next_val(r,  bus, clr_en[B_R],  write_en[B_R],  inc_en[B_R]);
      r1 <= next_val(r1, bus, clr_en[B_R1], write_en[B_R1], inc_en[B_R1]);
      r2 <= next_val(r2, bus, clr_en[B_R2], write_en[B_R2], inc_en[B_R2]);
      r3 <= next_val(r3, bus, clr_en[B_R3], write_en[B_R3], inc_en[B_R3]);
      r4 <= next_val(r4, bus, clr_en[B_R4], write_en[B_R4], inc_en[B_R4]);
      // The ALU result takes precedence over a bus load into AC.
      ac <= next_val(ac, write_en[B_ALU] ? alu_y : bus, clr_en[B_AC],
                     write_en[B_ALU] | write_en[B_AC], inc_en[B_AC]);
      // DR has no strobe: it captures memory whenever memory drives the bus.
      if (read_en == SRC_DM) dr <= dm_rdata;
    end
  end

`ifdef DATAPATH_R5_EN
  logic [15:0] r5;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r5 <= '0;
    else if (!halt) r5 <= next_val(r5, bus, clr_en[B_R5], write_en[B_R5], inc_en[B_R5]);
  end

  assign r5_val = r5;

  logic unused_strobes;
  assign unused_strobes = ^{write_en[15:13], write_en[0],
                            inc_en[15:11], inc_en[0],
                            clr_en[15:11], clr_en[0]};
`else
  assign r5_val = 16'h0000;

  logic unused_strobes;
  assign unused_strobes = ^{write_en[15:13], write_en[B_R5], write_en[0],
                            inc_en[15:11], inc_en[B_R5], inc_en[0],
                            clr_en[15:11], clr_en[B_R5], clr_en[0]};
`endif

  // Gated by rst_n so a write in flight is dropped the moment reset asserts.
  assign dm_we       = write_en[B_DMW] & ~halt & rst_n;
  assign dm_addr     = ar;
  assign dm_wdata    = bus;
  assign im_addr     = pc;
  assign z           = {15'b0, (ac == 16'h0000)};
  assign instruction = ir[5:0];

endmodule

// File: tb/tb_datapath_bus.sv
// tb_datapath_bus -- self-checking bench for datapath_bus: directed scenarios
// followed by randomized cycles checked against a table-driven register model.
module tb_datapath_bus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en, clr_en;
  logic [2:0]  alu_op;
  logic        halt;
  logic [15:0] im_addr, im_rdata, dm_addr, dm_wdata, dm_rdata, z, bus;
  logic        dm_we;
  logic [5:0]  instruction;

  int total = 0;
  int bad   = 0;

  datapath_bus dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
    .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op), .halt(halt),
    .im_addr(im_addr), .im_rdata(im_rdata), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata), .z(z),
    .instruction(instruction), .bus(bus)
  );

  always #10 clk = ~clk;

`ifdef DATAPATH_R5_EN
  localparam bit HAS_R5 = 1'b1;
`else
  localparam bit HAS_R5 = 1'b0;
`endif

  // Model state indexed by bus source code: 1 PC, 2 AR, 3 DR, 4 IR, 5 AC,
  // 6 R, 7 R1, 8 R2, 9 R3, 10 R4, 11 R5.
  logic [15:0] m [16];
  // Strobe bit -> bus source code of the register it controls (0 = none).
  int strobe_map [16] = '{0, 1, 2, 4, 5, 6, 11, 10, 9, 8, 7, 0, 0, 0, 0, 0};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_bus(input logic [3:0] code);
    if (code >= 1 && code <= 10)   return m[code];
    else if (code == 11)           return HAS_R5 ? m[11] : 16'h0000;
    else if (code == 12)           return dm_rdata;
    else if (code == 13)           return im_rdata;
    else if (code == 14)           return m[5];
    else                           return 16'h0000;
  endfunction

  function automatic logic [15:0] model_alu();
    logic [31:0] prod;
    case (alu_op)
      3'd1: return m[5] + m[6];
      3'd2: return m[5] - m[6];
      3'd3: begin prod = m[5] * m[6]; return prod[15:0]; end
      3'd4: return m[5] << 1;
      default: return m[5];
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = 16'h0000;
  endtask

  task automatic model_step();
    logic [15:0] nm [16];
    logic [15:0] b, v;
    int code;
    if (halt) return;
    b = model_bus(read_en);
    nm = m;
    for (int s = 1; s <= 10; s++) begin
      if (s == 6 && !HAS_R5) continue;
      code = strobe_map[s];
      v = m[code];
      if (clr_en[s])                    v = 16'h0000;
      else if (s == 4 && write_en[12])  v = model_alu();
      else if (write_en[s])             v = b;
      else if (inc_en[s])               v = m[code] + 16'h0001;
      nm[code] = v;
    end
    if (read_en == 4'd12) nm[3] = dm_rdata;
    m = nm;
  endtask

  task automatic check_state_outputs(input string tag);
    check({tag, ".im_addr"}, im_addr, m[1]);
    check({tag, ".dm_addr"}, dm_addr, m[2]);
    check({tag, ".instr"}, {10'b0, instruction}, {10'b0, m[4][5:0]});
    check({tag, ".z"}, z, {15'b0, m[5] == 16'h0000});
  endtask

  // Check combinational outputs against the model, then advance one edge.
  task automatic tick(input string tag);
    #1;
    check({tag, ".bus"}, bus, model_bus(read_en));
    check({tag, ".wdata"}, dm_wdata, model_bus(read_en));
    check({tag, ".dm_we"}, {15'b0, dm_we}, {15'b0, write_en[11] & ~halt});
    model_step();
    @(posedge clk);
    #1;
    check_state_outputs(tag);
  endtask

  task automatic peek(input string tag, input logic [3:0] code, input logic [15:0] exp);
    logic [3:0] sv_re;
    logic sv_h;
    sv_re = read_en; sv_h = halt;
    halt = 1'b1; read_en = code;
    #1;
    check(tag, bus, exp);
    read_en = sv_re; halt = sv_h;
  endtask

  task automatic peek_all(input string tag);
    for (int c = 1; c <= 11; c++) peek($sformatf("%s.reg%0d", tag, c), 4'(c), model_bus(4'(c)));
  endtask

  task automatic idle();
    read_en = 0; write_en = 0; inc_en = 0; clr_en = 0; alu_op = 0; halt = 0;
  endtask

  task automatic load(input int bit_idx, input logic [15:0] val, input string tag);
    idle();
    read_en = 4'd13; im_rdata = val; write_en[bit_idx] = 1'b1;
    tick(tag);
  endtask

  initial begin
    idle();
    im_rdata = 16'h0; dm_rdata = 16'h0;
    rst_n = 1'b0;
    model_reset();
    write_en = 16'hFFFF;
    #5;
    check("rst.z", z, 16'h0001);
    check("rst.instr", {10'b0, instruction}, 16'h0000);
    check("rst.dm_we", {15'b0, dm_we}, 16'h0000);
    check("rst.im_addr", im_addr, 16'h0000);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch: IR <- im_rdata, PC++ on the same edge.
    idle();
    read_en = 4'd13; im_rdata = 16'h0013; write_en[3] = 1'b1; inc_en[1] = 1'b1;
    tick("fetch");
    check("fetch.instr", {10'b0, instruction}, 16'd19);
    check("fetch.pc", im_addr, 16'h0001);
    peek("fetch.ir", 4'd4, 16'h0013);

    // ALU subtract and multiply.
    load(4, 16'h0005, "ld_ac");
    load(5, 16'h0003, "ld_r");
    idle(); alu_op = 3'd2; write_en[12] = 1'b1;
    tick("alu_sub");
    peek("alu_sub.ac", 4'd5, 16'h0002);
    idle(); alu_op = 3'd3; write_en[12] = 1'b1;
    tick("alu_mul");
    peek("alu_mul.ac", 4'd5, 16'h0006);

    // AC increment wrap and clear priority.
    load(4, 16'hFFFF, "ld_ffff");
    idle(); inc_en[4] = 1'b1;
    tick("ac_wrap");
    check("ac_wrap.z", z, 16'h0001);
    peek("ac_wrap.ac", 4'd5, 16'h0000);
    load(4, 16'hFFFF, "ld_ffff2");
    idle(); read_en = 4'd13; im_rdata = 16'h0077;
    inc_en[4] = 1'b1; clr_en[4] = 1'b1; write_en[4] = 1'b1;
    tick("ac_clr_pri");
    peek("ac_clr_pri.ac", 4'd5, 16'h0000);

    // Data-memory write, then the same strobes under halt.
    load(2, 16'h0040, "ld_ar");
    load(4, 16'h1234, "ld_ac2");
    idle(); read_en = 4'd5; write_en[11] = 1'b1;
    #1;
    check("dmw.we", {15'b0, dm_we}, 16'h0001);
    check("dmw.addr", dm_addr, 16'h0040);
    check("dmw.wdata", dm_wdata, 16'h1234);
    tick("dmw");
    idle(); halt = 1'b1; read_en = 4'd13; im_rdata = 16'h5A5A;
    write_en = 16'hFFFF; inc_en = 16'hFFFF;
    #1;
    check("halt.we", {15'b0, dm_we}, 16'h0000);
    check("halt.bus", bus, 16'h5A5A);
    tick("halt");
    peek_all("halt");

    // Asynchronous reset between edges, with strobes active throughout.
    load(1, 16'h0007, "ld_pc");
    check("ld_pc.pc", im_addr, 16'h0007);
    idle(); read_en = 4'd13; im_rdata = 16'h0055; write_en[1] = 1'b1; write_en[11] = 1'b1;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.pc", im_addr, 16'h0000);
    check("arst.dm_we", {15'b0, dm_we}, 16'h0000);
    check("arst.z", z, 16'h0001);
    #2;
    rst_n = 1'b1;
    tick("post_rst");
    check("post_rst.pc", im_addr, 16'h0055);

    // Optional R5 through bus source 11.
    load(6, 16'hABCD, "ld_r5");
    idle(); read_en = 4'd11;
    #1;
    check("r5.bus", bus, HAS_R5 ? 16'hABCD : 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      read_en  = 4'($urandom_range(0, 15));
      write_en = 16'($urandom & $urandom & $urandom);
      inc_en   = 16'($urandom & $urandom & $urandom);
      clr_en   = 16'($urandom & $urandom & $urandom & $urandom);
      alu_op   = 3'($urandom_range(0, 7));
      halt     = ($urandom_range(0, 7) == 0);
      im_rdata = 16'($urandom);
      dm_rdata = 16'($urandom);
      tick($sformatf("rnd%0d", i));
      if (i % 25 == 24) peek_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
